// File: rtl/muldiv_unit_pkg.sv
// Shared opcode encoding, result constants and FSM state encoding for muldiv_unit.
package muldiv_unit_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OPNULL   = 5'd0;
    localparam logic [OP_W-1:0] OPMUL    = 5'd8;
    localparam logic [OP_W-1:0] OPMULH   = 5'd9;
    localparam logic [OP_W-1:0] OPMULHU  = 5'd10;
    localparam logic [OP_W-1:0] OPMULHSU = 5'd11;
    localparam logic [OP_W-1:0] OPDIV    = 5'd12;
    localparam logic [OP_W-1:0] OPDIVU   = 5'd13;
    localparam logic [OP_W-1:0] OPREM    = 5'd14;
    localparam logic [OP_W-1:0] OPREMU   = 5'd15;

    localparam logic [31:0] ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic is_mul_op(input logic [OP_W-1:0] op);
        return (op == OPMUL) || (op == OPMULH) || (op == OPMULHU) || (op == OPMULHSU);
    endfunction

    function automatic logic is_rem_op(input logic [OP_W-1:0] op);
        return (op == OPREM) || (op == OPREMU);
    endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Restoring radix-2 unsigned divider: load on start, one quotient bit per step.
module muldiv_divider #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] dvsr_r;
    logic [XLEN:0]   trial_c;
    logic            borrow_c;

    // Partial remainder shifted left with the next dividend bit brought in
    assign trial_c  = {remainder, quotient[XLEN-1]};
    assign borrow_c = trial_c < {1'b0, dvsr_r};

    always_ff @(posedge clk) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
            dvsr_r    <= '0;
        end else if (start) begin
            quotient  <= dividend;
            remainder <= '0;
            dvsr_r    <= divisor;
        end else if (step) begin
            remainder <= borrow_c ? XLEN'(trial_c) : XLEN'(trial_c - {1'b0, dvsr_r});
            quotient  <= {quotient[XLEN-2:0], ~borrow_c};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle M-extension unit (MUL*/DIV*/REM*) with start/done handshake.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle 33x33 multiply.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iStart,
    input  logic [4:0]      iControl,
    input  logic [XLEN-1:0] iA,
    input  logic [XLEN-1:0] iB,
    output logic            oBusy,
    output logic            oDone,
    output logic [XLEN-1:0] oResult
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  ALL_ONES = '1;
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state;
    logic [CNT_W-1:0]  cnt;
    logic [4:0]        op_r;
    logic              sign_r;
    logic [XLEN-1:0]   mcand_r;
    logic [2*XLEN-1:0] prod_r;

    logic              a_neg, b_neg, ovf_c;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN-1:0]   mag_a_c, mag_b_c, sc_val_c, fix_res_c;
    logic              sgn_c, sc_c;
    logic [XLEN:0]     sum_c;
    logic [2*XLEN-1:0] mul_full_c;
    logic [XLEN-1:0]   quot, rem;
    logic              accept_c, div_start_c;

    assign a_neg    = iA[XLEN-1];
    assign b_neg    = iB[XLEN-1];
    assign abs_a    = a_neg ? -iA : iA;
    assign abs_b    = b_neg ? -iB : iB;
    assign ovf_c    = (iA == INT_MIN) && (iB == ALL_ONES);
    assign accept_c = iStart && ((state == IDLE) || (state == DONE));

`ifdef MULDIV_FAST_MUL_EN
    logic              fast_a_ext, fast_b_ext;
    logic signed [2*XLEN+1:0] fast_p_c;

    // Sign/zero extension per operand so one signed multiplier covers all four MUL variants
    assign fast_a_ext = (iControl == OPMULHU) ? 1'b0 : a_neg;
    assign fast_b_ext = ((iControl == OPMUL) || (iControl == OPMULH)) ? b_neg : 1'b0;
    assign fast_p_c   = $signed({fast_a_ext, iA}) * $signed({fast_b_ext, iB});
`endif

    // Operand magnitudes, result sign and short-circuit detection at accept
    always_comb begin
        mag_a_c  = iA;
        mag_b_c  = iB;
        sgn_c    = 1'b0;
        sc_c     = 1'b1;
        sc_val_c = ZERO;
        case (iControl)
            OPMUL:   sc_c = 1'b0;
            OPMULH: begin
                mag_a_c = abs_a;
                mag_b_c = abs_b;
                sgn_c   = a_neg ^ b_neg;
                sc_c    = 1'b0;
            end
            OPMULHU: sc_c = 1'b0;
            OPMULHSU: begin
                mag_a_c = abs_a;
                sgn_c   = a_neg;
                sc_c    = 1'b0;
            end
            OPDIV: begin
                mag_a_c = abs_a;
                mag_b_c = abs_b;
                sgn_c   = a_neg ^ b_neg;
                if (iB == '0)  sc_val_c = ALL_ONES;
                else if (ovf_c) sc_val_c = INT_MIN;
                else            sc_c = 1'b0;
            end
            OPDIVU: begin
                if (iB == '0) sc_val_c = ALL_ONES;
                else          sc_c = 1'b0;
            end
            OPREM: begin
                mag_a_c = abs_a;
                mag_b_c = abs_b;
                sgn_c   = a_neg;
                if (iB == '0)  sc_val_c = iA;
                else if (ovf_c) sc_val_c = ZERO;
                else            sc_c = 1'b0;
            end
            OPREMU: begin
                if (iB == '0) sc_val_c = iA;
                else          sc_c = 1'b0;
            end
            default: ;
        endcase
`ifdef MULDIV_FAST_MUL_EN
        if (is_mul_op(iControl)) begin
            sc_c     = 1'b1;
            sc_val_c = (iControl == OPMUL) ? XLEN'(fast_p_c) : XLEN'(fast_p_c >> XLEN);
        end
`endif
    end

    assign div_start_c = accept_c && !sc_c && !is_mul_op(iControl);

    muldiv_divider #(.XLEN(XLEN)) u_div (
        .clk       (iCLK),
        .rst       (iRST),
        .start     (div_start_c),
        .step      ((state == CALC) && !is_mul_op(op_r)),
        .dividend  (mag_a_c),
        .divisor   (mag_b_c),
        .quotient  (quot),
        .remainder (rem)
    );

    // Shift-add step: conditionally add multiplicand to the upper half, then shift right
    assign sum_c      = {1'b0, prod_r[2*XLEN-1:XLEN]} + (prod_r[0] ? {1'b0, mcand_r} : '0);
    assign mul_full_c = sign_r ? -prod_r : prod_r;

    // Sign correction and result select in FIX
    always_comb begin
        fix_res_c = ZERO;
        if (op_r == OPMUL)
            fix_res_c = prod_r[XLEN-1:0];
        else if (is_mul_op(op_r))
            fix_res_c = XLEN'(mul_full_c >> XLEN);
        else if (is_rem_op(op_r))
            fix_res_c = sign_r ? -rem : rem;
        else
            fix_res_c = sign_r ? -quot : quot;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state   <= IDLE;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oResult <= ZERO;
            cnt     <= '0;
            op_r    <= OPNULL;
            sign_r  <= 1'b0;
            mcand_r <= '0;
            prod_r  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    oDone <= 1'b0;
                    if (iStart) begin
                        op_r   <= iControl;
                        sign_r <= sgn_c;
                        cnt    <= '0;
                        if (sc_c) begin
                            state   <= DONE;
                            oDone   <= 1'b1;
                            oResult <= sc_val_c;
                        end else begin
                            state   <= CALC;
                            oBusy   <= 1'b1;
                            mcand_r <= mag_a_c;
                            prod_r  <= {{XLEN{1'b0}}, mag_b_c};
                        end
                    end
                end
                CALC: begin
                    if (is_mul_op(op_r))
                        prod_r <= {sum_c, prod_r[XLEN-1:1]};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST)
                        state <= FIX;
                end
                FIX: begin
                    state   <= DONE;
                    oBusy   <= 1'b0;
                    oDone   <= 1'b1;
                    oResult <= fix_res_c;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard testbench for muldiv_unit: directed cases, handshake corner cases and random vectors.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int ITER_LAT = 34;
    localparam int SC_LAT   = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  ctrl = OPNULL;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .iCLK     (clk),
        .iRST     (rst),
        .iStart   (start),
        .iControl (ctrl),
        .iA       (a),
        .iB       (b),
        .oBusy    (busy),
        .oDone    (done),
        .oResult  (result)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0]        up;
        logic signed [63:0] sp;
        logic signed [64:0] su;
        logic signed [31:0] sq;
        case (op)
            OPMUL: begin
                up = {32'b0, x} * {32'b0, y};
                return up[31:0];
            end
            OPMULH: begin
                sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                return sp[63:32];
            end
            OPMULHU: begin
                up = {32'b0, x} * {32'b0, y};
                return up[63:32];
            end
            OPMULHSU: begin
                su = $signed({{33{x[31]}}, x}) * $signed({33'b0, y});
                return su[63:32];
            end
            OPDIV: begin
                if (y == 32'h0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                sq = $signed(x) / $signed(y);
                return sq;
            end
            OPDIVU: return (y == 32'h0) ? 32'hFFFF_FFFF : x / y;
            OPREM: begin
                if (y == 32'h0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
                sq = $signed(x) % $signed(y);
                return sq;
            end
            OPREMU: return (y == 32'h0) ? x : x % y;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        if (op == OPMUL || op == OPMULH || op == OPMULHU || op == OPMULHSU) return MUL_LAT;
        if (op == OPDIV || op == OPDIVU || op == OPREM || op == OPREMU) begin
            if (y == 32'h0) return SC_LAT;
            if ((op == OPDIV || op == OPREM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return SC_LAT;
            return ITER_LAT;
        end
        return SC_LAT;
    endfunction

    // Waits for oDone from a negedge after the accept edge; checks busy profile, latency and result
    task automatic wait_done(input string nm, input int exp_lat, input int lat0, input int poke_at);
        int lat;
        logic busy_bad;
        logic [31:0] exp;
        lat = lat0;
        busy_bad = 1'b0;
        forever begin
            @(negedge clk);
            lat++;
            if (poke_at > 0) begin
                if (lat == poke_at) begin
                    ctrl  = OPDIVU;
                    a     = 32'h1;
                    b     = 32'h0;
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
            if (busy !== (lat < exp_lat)) busy_bad = 1'b1;
            if (done === 1'b1 || lat >= 200) break;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: no oDone after %0d cycles", nm, lat);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        exp = exp_q.pop_front();
        if (result !== exp) begin
            n_fail++;
            $display("FAIL %s result: got %h expected %h", nm, result, exp);
        end
        n_tests++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", nm, lat, exp_lat);
        end
        n_tests++;
        if (busy_bad) begin
            n_fail++;
            $display("FAIL %s busy: oBusy profile wrong, got %b at done expected 0 and high for cycles 1..%0d", nm, busy, exp_lat - 1);
        end
    endtask

    task automatic issue(input string nm, input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input int exp_lat, input int poke_at);
        @(negedge clk);
        ctrl  = op;
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(nm, exp_lat, 0, poke_at);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h expected 0 0 00000000", busy, done, result);
        end
    endtask

    task automatic test_mul();
        issue("mul_7x-3",      OPMUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 0);
        issue("mulh_min",      OPMULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 0);
        issue("mulhu_max",     OPMULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 0);
        issue("mulhsu_neg",    OPMULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 0);
    endtask

    task automatic test_div();
        issue("div_-7/2",      OPDIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, ITER_LAT, 0);
        issue("rem_-7/2",      OPREM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, ITER_LAT, 0);
        issue("divu_100/7",    OPDIVU,   32'd100,       32'd7,         32'd14,        ITER_LAT, 0);
        issue("remu_100/7",    OPREMU,   32'd100,       32'd7,         32'd2,         ITER_LAT, 0);
    endtask

    task automatic test_special();
        issue("div_by_zero",   OPDIV,    32'h0000_0055, 32'h0,         32'hFFFF_FFFF, SC_LAT, 0);
        issue("remu_by_zero",  OPREMU,   32'h0000_1234, 32'h0,         32'h0000_1234, SC_LAT, 0);
        issue("div_overflow",  OPDIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SC_LAT, 0);
        issue("rem_overflow",  OPREM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         SC_LAT, 0);
        issue("divu_ones",     OPDIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         ITER_LAT, 0);
        issue("preload",       OPDIVU,   32'h0,         32'h0,         32'hFFFF_FFFF, SC_LAT, 0);
        issue("opnull",        OPNULL,   32'h1234_5678, 32'h9,         32'h0,         SC_LAT, 0);
        issue("preload2",      OPREMU,   32'hCAFE,      32'h0,         32'hCAFE,      SC_LAT, 0);
        issue("non_m_op",      5'd31,    32'h1234_5678, 32'h9,         32'h0,         SC_LAT, 0);
    endtask

    task automatic test_ignore_start();
        issue("div_ignore_start", OPDIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, ITER_LAT, 5);
    endtask

    task automatic test_back_to_back();
        issue("b2b_first_div", OPDIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, ITER_LAT, 0);
        ctrl  = OPDIVU;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        exp_q.push_back(32'd14);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || result !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL b2b_hold: got done=%b result=%h expected 0 fffffffd", done, result);
        end
        wait_done("b2b_divu", ITER_LAT, 1, 0);
        ctrl  = OPDIV;
        a     = 32'd5;
        b     = 32'd0;
        start = 1'b1;
        exp_q.push_back(32'hFFFF_FFFF);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("b2b_shortcut", SC_LAT, 0, 0);
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        @(negedge clk);
        ctrl  = OPDIV;
        a     = 32'd1000;
        b     = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || result !== 32'h0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_state: got busy=%b done=%b result=%h expected 0 0 00000000", busy, done, result);
        end
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL reset_mid_nodone: got an oDone pulse expected none");
        end
    endtask

    task automatic test_random();
        logic [4:0]  op;
        logic [31:0] x, y;
        for (int i = 0; i < 300; i++) begin
            op = OPMUL + 5'($urandom_range(0, 7));
            x  = $urandom();
            y  = $urandom();
            case ($urandom_range(0, 15))
                0: y = 32'h0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: x = 32'h0;
                3: y = 32'($urandom_range(1, 15));
                default: ;
            endcase
            issue("random", op, x, y, ref_model(op, x, y), ref_latency(op, x, y), 0);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
